axi4lite_rd_timeout32: RTL

Read-path watchdog for the 32-bit AXI4-Lite slave side of the 64-to-32 bridge. Sits directly downstream of the read handler, between its 32-bit AR/R outputs and the slave fabric. Forwards one read at a time. If the slave does not complete a read within a programmable cycle budget, the block answers upstream with SLVERR and ERR_DATA, then drains the late AR/R handshakes from the slave so protocol state stays consistent.

---
 rtl/axi4lite_rd_timeout_pkg.sv | 16 +
 rtl/axi4lite_rd_timeout_cnt.sv | 33 +++
 rtl/axi4lite_rd_timeout32.sv | 137 +++++++++++++
 3 files changed

// File: rtl/axi4lite_rd_timeout_pkg.sv
// Shared definitions for the AXI4-Lite read-path watchdog.
// Contents: FSM state encodings (IDLE/WAIT/RESP/DRAIN) and AXI response codes.
// No ports; imported by axi4lite_rd_timeout32 and its counter.
package axi4lite_rd_timeout_pkg;

  // FSM state encoding, kept as plain constants for legacy tool flows.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_WAIT  = 2'd1;
  localparam state_t ST_RESP  = 2'd2;
  localparam state_t ST_DRAIN = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi4lite_rd_timeout_cnt.sv
// Watchdog cycle counter: counts enabled cycles, saturating at TIMEOUT_CYCLES-1.
// Latency: expire is combinational from the count register and enable.
// Backpressure: none; clear wins over enable.
// Ports: clk, rst_n (async active-low), clear, enable -> expire.
module axi4lite_rd_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Stops at the compare value so it can never wrap back into range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = enable && (cnt == LIMIT);

endmodule

// File: rtl/axi4lite_rd_timeout32.sv
// Read-path watchdog between the 32-bit read handler and the slave fabric.
// Latency: +1 cycle AR (upstream->slave), +1 cycle R (slave->upstream).
// Backpressure: one read in flight; u_arready low until the slave is fully drained.
// Ports: u_ar*/u_r* upstream slave side, d_ar*/d_r* downstream master side,
//   clk, rst_n (async active-low). Optional AXI4LITE_RD_TIMEOUT_STATS_EN adds
//   timeout_cnt[15:0] (saturating) and timeout_sticky.
module axi4lite_rd_timeout32
  import axi4lite_rd_timeout_pkg::*;
#(
  parameter int              ADDR_WIDTH     = 32,
  parameter int              TIMEOUT_CYCLES = 1024,
  parameter logic [31:0]     ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] u_araddr,
  input  logic                  u_arvalid,
  output logic                  u_arready,
  output logic [1:0]            u_rresp,
  output logic [31:0]           u_rdata,
  output logic                  u_rvalid,
  input  logic                  u_rready,
  output logic [ADDR_WIDTH-1:0] d_araddr,
  output logic                  d_arvalid,
  input  logic                  d_arready,
  input  logic [1:0]            d_rresp,
  input  logic [31:0]           d_rdata,
  input  logic                  d_rvalid,
  output logic                  d_rready
`ifdef AXI4LITE_RD_TIMEOUT_STATS_EN
  ,
  output logic [15:0]           timeout_cnt,
  output logic                  timeout_sticky
`endif
);

  state_t state;
  state_t nxt_state;
  logic   ar_pend;
  logic   r_owed;
  logic   timed_out;
  logic   expire;

  logic accept;
  logic ar_hs;
  logic r_hs;
  logic u_r_hs;

  // u_arready is its own register (low in reset) so it never depends on inputs.
  assign accept = u_arready && u_arvalid;
  assign ar_hs  = d_arvalid && d_arready;
  assign r_hs   = d_rvalid && d_rready;
  assign u_r_hs = u_rvalid && u_rready;

  // Flags are only non-zero while a read (or its drain) is live, so the
  // downstream handshakes can be driven straight from them in every state.
  // R is not taken before AR has gone, keeping the slave's view ordered.
  assign d_arvalid = ar_pend;
  assign d_rready  = r_owed && !ar_pend;
  assign u_rvalid  = (state == ST_RESP);

  axi4lite_rd_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept),
    .enable (state == ST_WAIT),
    .expire (expire)
  );

  always_comb begin
    nxt_state = state;
    case (state)
      ST_IDLE:  if (accept) nxt_state = ST_WAIT;
      ST_WAIT:  if (r_hs || expire) nxt_state = ST_RESP;
      ST_RESP:  if (u_r_hs) nxt_state = (ar_pend || r_owed) ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: if (!ar_pend && !r_owed) nxt_state = ST_IDLE;
      default:  nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      u_arready <= 1'b0;
      ar_pend   <= 1'b0;
      r_owed    <= 1'b0;
      timed_out <= 1'b0;
      d_araddr  <= '0;
      u_rresp   <= 2'b00;
      u_rdata   <= 32'h0;
    end else begin
      state     <= nxt_state;
      u_arready <= (nxt_state == ST_IDLE);

      if (accept) begin
        d_araddr <= u_araddr;
        ar_pend  <= 1'b1;
        r_owed   <= 1'b1;
      end else begin
        if (ar_hs) ar_pend <= 1'b0;
        if (r_hs)  r_owed  <= 1'b0;
      end

      // A real beat arriving in the expiry cycle takes priority over the error.
      if (state == ST_WAIT) begin
        if (r_hs) begin
          u_rresp <= d_rresp;
          u_rdata <= d_rdata;
        end else if (expire) begin
          u_rresp   <= RESP_SLVERR;
          u_rdata   <= ERR_DATA;
          timed_out <= 1'b1;
        end
      end

      if (nxt_state == ST_IDLE) timed_out <= 1'b0;
    end
  end

`ifdef AXI4LITE_RD_TIMEOUT_STATS_EN
  logic to_event;
  assign to_event = (state == ST_WAIT) && expire && !r_hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_cnt    <= 16'h0;
      timeout_sticky <= 1'b0;
    end else if (to_event) begin
      if (timeout_cnt != 16'hFFFF) timeout_cnt <= timeout_cnt + 16'd1;
      timeout_sticky <= 1'b1;
    end
  end
`endif

endmodule
